fnd_scan_ctrl: RTL

Display scheduler for the 4-digit common-anode FND. It accepts a binary result from the adder datapath through a valid/busy handshake and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes the single shared segment bus across the four digits, with optional leading-zero blanking and overflow indication. It sits between the adder output and the board's `fnd_digit`/`fnd_data` pins.

---
 rtl/fnd_scan_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fnd_scan_ctrl.sv
// Display scheduler for a 4-digit common-anode FND: sequential double-dabble
// conversion of a 14-bit value, then free-running time-multiplexed digit scan.
module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        value_valid,
    input  logic [13:0] value,
    input  logic        blank_lz,
    output logic        busy,
    output logic [3:0]  fnd_digit,
    output logic [7:0]  fnd_data
);

    localparam int unsigned     CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]      ITER_LAST = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_e;

    state_e          state_q, state_d;
    logic [13:0]     shreg_q, shreg_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [3:0]      iter_q, iter_d;
    logic            ovf_cap_q, ovf_cap_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            ovf_q, ovf_d;
    logic            busy_q;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            tick;
    logic [3:0]      digit_q, digit_d;
    logic [7:0]      data_q, data_d;

    logic [15:0]     bcd_adj;
    logic [29:0]     dd_shift;
    logic [3:0]      nib;
    logic            zero_from3, zero_from2, zero_from1;
    logic            blank_sel;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Double-dabble add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dd_shift = {bcd_adj, shreg_q} << 1;
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        ovf_cap_d = ovf_cap_q;
        dig_d     = dig_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    shreg_d   = value;
                    bcd_d     = '0;
                    iter_d    = '0;
                    ovf_cap_d = (value > 14'd9999);
                    state_d   = CONV;
                end
            end
            CONV: begin
                bcd_d   = dd_shift[29:14];
                shreg_d = dd_shift[13:0];
                iter_d  = iter_q + 4'd1;
                if (iter_q == ITER_LAST) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dig_d   = bcd_q;
                ovf_d   = ovf_cap_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            ovf_cap_q <= 1'b0;
            dig_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            ovf_cap_q <= ovf_cap_d;
            dig_q     <= dig_d;
            ovf_q     <= ovf_d;
            busy_q    <= (state_q != IDLE);
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        sel_d = tick ? sel_q + 2'd1 : sel_q;
    end

    // Digit k is a leading zero when it and every more significant digit are 0.
    always_comb begin
        nib        = dig_q[sel_q];
        zero_from3 = (dig_q[3] == 4'd0);
        zero_from2 = zero_from3 && (dig_q[2] == 4'd0);
        zero_from1 = zero_from2 && (dig_q[1] == 4'd0);
        case (sel_q)
            2'd1:    blank_sel = zero_from1;
            2'd2:    blank_sel = zero_from2;
            2'd3:    blank_sel = zero_from3;
            default: blank_sel = 1'b0;
        endcase

        digit_d = ~(4'b0001 << sel_q);
        if (ovf_q) begin
            data_d = 8'hBF;
        end else if (blank_lz && blank_sel) begin
            data_d = 8'hFF;
        end else begin
            data_d = seg_decode(nib);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            digit_q <= 4'b1110;
            data_q  <= 8'hC0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            digit_q <= digit_d;
            data_q  <= data_d;
        end
    end

    assign busy      = busy_q;
    assign fnd_digit = digit_q;
    assign fnd_data  = data_q;

endmodule
